// File: rtl/ebi_pkg.sv
// ebi_pkg: shared definitions for the EBI arbiter.
//   - ebi_state_e     : arbiter FSM state encoding (IDLE, WR, RD, GAP)
//   - EBI_AW, EBI_DW  : EBI address / data widths
//   - EBI_STROBE_IDLE : inactive level of the active-low EBI strobes
package ebi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_GAP  = 2'd3
  } ebi_state_e;

  localparam int   EBI_AW          = 16;
  localparam int   EBI_DW          = 16;
  localparam logic EBI_STROBE_IDLE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
// The search starts at ptr+1 and wraps modulo NUM_REQ. The first set request
// bit found is granted. Driving ptr = NUM_REQ-1 turns the search into a
// fixed lowest-index-first priority.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    index of the last granted requester
//   grant     out NUM_REQ  one-hot grant (all zero when req is zero)
//   grant_idx out IDX_W    binary index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan the requesters in rotating order; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ebi_arbiter.sv
// ebi_arbiter: shares one active-low EBI slave bus between NUM_REQ requesters.
// Each requester issues single 16-bit reads or writes. Only one requester is
// served at a time. Every transaction is followed by one GAP turnaround cycle
// before the next grant.
// Optional macro EBI_ARB_FIXED_PRIO_EN: when defined, the lowest-index
// requester always wins. Otherwise grants are round-robin.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/we         per-requester command valid and write flag
//   req_addr/wdata       packed 16-bit fields, requester i at [16i+15:16i]
//   req_ready            one-hot acceptance pulse (same cycle as the grant)
//   rsp_valid/rsp_rdata  one-hot completion pulse and read data (held)
//   ebi_cs/rden/wren     active-low EBI strobes
//   ebi_addr/dout/din    EBI address, write data, read data
//   busy                 FSM is not idle
module ebi_arbiter
  import ebi_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int WR_SETUP = 2,
  parameter int WR_TOTAL = 5,
  parameter int RD_TOTAL = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [EBI_AW*NUM_REQ-1:0] req_addr,
  input  logic [EBI_DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [EBI_DW-1:0]         rsp_rdata,
  output logic                      ebi_cs,
  output logic                      ebi_rden,
  output logic                      ebi_wren,
  output logic [EBI_AW-1:0]         ebi_addr,
  output logic [EBI_DW-1:0]         ebi_dout,
  input  logic [EBI_DW-1:0]         ebi_din,
  output logic                      busy
);

  localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] WR_SETUP_C = 4'(WR_SETUP);
  localparam logic [3:0] WR_TOTAL_C = 4'(WR_TOTAL);
  localparam logic [3:0] RD_TOTAL_C = 4'(RD_TOTAL);

  ebi_state_e         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [EBI_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               ebi_cs_q, ebi_cs_d;
  logic               ebi_rden_q, ebi_rden_d;
  logic               ebi_wren_q, ebi_wren_d;
  logic [EBI_AW-1:0]  ebi_addr_q, ebi_addr_d;
  logic [EBI_DW-1:0]  ebi_dout_q, ebi_dout_d;

  logic [PTR_W-1:0]   arb_ptr_s;
  logic [NUM_REQ-1:0] arb_grant_s;
  logic [PTR_W-1:0]   arb_idx_s;

`ifdef EBI_ARB_FIXED_PRIO_EN
  // A pointer pinned at the top index makes the search start at requester 0.
  assign arb_ptr_s = PTR_W'(NUM_REQ - 1);
`else
  assign arb_ptr_s = ptr_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (arb_ptr_s),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // Acceptance is combinational so req_ready coincides with the grant cycle.
  assign req_ready = (state_q == ST_IDLE && !rst) ? arb_grant_s : '0;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ebi_cs    = ebi_cs_q;
  assign ebi_rden  = ebi_rden_q;
  assign ebi_wren  = ebi_wren_q;
  assign ebi_addr  = ebi_addr_q;
  assign ebi_dout  = ebi_dout_q;

  // Next-state logic. The strobes are derived from the next state and count.
  // This lets the registered pins line up with cnt: in the cycle where
  // cnt == *_TOTAL, cs is already high and rsp_valid is visible.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    ebi_addr_d = ebi_addr_q;
    ebi_dout_d = ebi_dout_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant_s) begin
          gnt_d = arb_grant_s;
`ifndef EBI_ARB_FIXED_PRIO_EN
          ptr_d = arb_idx_s;
`endif
          cnt_d      = 4'd0;
          ebi_addr_d = req_addr[int'(arb_idx_s)*EBI_AW +: EBI_AW];
          if (req_we[arb_idx_s]) begin
            ebi_dout_d = req_wdata[int'(arb_idx_s)*EBI_DW +: EBI_DW];
            state_d    = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (cnt_q == WR_TOTAL_C) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_TOTAL_C) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ebi_cs_d    = !(((state_d == ST_WR) && (cnt_d < WR_TOTAL_C)) ||
                    ((state_d == ST_RD) && (cnt_d < RD_TOTAL_C)));
    ebi_wren_d  = !((state_d == ST_WR) && (cnt_d >= WR_SETUP_C) && (cnt_d < WR_TOTAL_C));
    ebi_rden_d  = !((state_d == ST_RD) && (cnt_d < RD_TOTAL_C));
    rsp_valid_d = (((state_d == ST_WR) && (cnt_d == WR_TOTAL_C)) ||
                   ((state_d == ST_RD) && (cnt_d == RD_TOTAL_C))) ? gnt_d : '0;
    // Sample ebi_din on the last rden-low cycle.
    rsp_rdata_d = ((state_d == ST_RD) && (cnt_d == RD_TOTAL_C)) ? ebi_din : rsp_rdata_q;
  end

  // State and output registers; reset forces the strobes inactive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      ebi_cs_q    <= EBI_STROBE_IDLE;
      ebi_rden_q  <= EBI_STROBE_IDLE;
      ebi_wren_q  <= EBI_STROBE_IDLE;
      ebi_addr_q  <= '0;
      ebi_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ebi_cs_q    <= ebi_cs_d;
      ebi_rden_q  <= ebi_rden_d;
      ebi_wren_q  <= ebi_wren_d;
      ebi_addr_q  <= ebi_addr_d;
      ebi_dout_q  <= ebi_dout_d;
    end
  end

endmodule

// File: tb/tb_ebi_arbiter.sv
// tb_ebi_arbiter: directed self-checking bench for ebi_arbiter (NUM_REQ = 2,
// default timing parameters). Inputs are driven 1 ns after the rising edge.
// A monitor samples the DUT on the falling edge and records grant and
// response cycles together with strobe low-run lengths.
module tb_ebi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld [2];
  logic        we_a [2];
  logic [15:0] addr_a [2];
  logic [15:0] wd_a [2];
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] rsp_rdata, ebi_addr, ebi_dout, ebi_din;
  logic        ebi_cs, ebi_rden, ebi_wren, busy;

  assign req_valid = {vld[1], vld[0]};
  assign req_we    = {we_a[1], we_a[0]};
  assign req_addr  = {addr_a[1], addr_a[0]};
  assign req_wdata = {wd_a[1], wd_a[0]};

  always #5 clk = ~clk;

  ebi_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ebi_cs    (ebi_cs),
    .ebi_rden  (ebi_rden),
    .ebi_wren  (ebi_wren),
    .ebi_addr  (ebi_addr),
    .ebi_dout  (ebi_dout),
    .ebi_din   (ebi_din),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state.
  int          cyc = 0;
  int          ready_cyc [2] = '{0, 0};
  int          ready_cnt [2] = '{0, 0};
  int          rsp_cyc [2]   = '{0, 0};
  int          rsp_cnt [2]   = '{0, 0};
  logic [15:0] rsp_data = 16'h0000;
  int          gq [$];
  int          gcyc [$];
  int          cs_run = 0, cs_last = 0;
  int          wren_run = 0, wren_last = 0, wren_off = -1;
  int          rden_run = 0, rden_last = 0;

  // Falling-edge monitor.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i]) begin
        ready_cyc[i] <= cyc;
        ready_cnt[i] <= ready_cnt[i] + 1;
        gq.push_back(i);
        gcyc.push_back(cyc);
      end
      if (rsp_valid[i]) begin
        rsp_cyc[i] <= cyc;
        rsp_cnt[i] <= rsp_cnt[i] + 1;
        rsp_data   <= rsp_rdata;
      end
    end
    if (!ebi_cs) begin
      if (!ebi_wren && wren_run == 0) wren_off <= cs_run;
      cs_run <= cs_run + 1;
    end else if (cs_run != 0) begin
      cs_last <= cs_run;
      cs_run  <= 0;
    end
    if (!ebi_wren) wren_run <= wren_run + 1;
    else if (wren_run != 0) begin
      wren_last <= wren_run;
      wren_run  <= 0;
    end
    if (!ebi_rden) rden_run <= rden_run + 1;
    else if (rden_run != 0) begin
      rden_last <= rden_run;
      rden_run  <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and wait (bounded) for its acceptance; valid stays high.
  task automatic issue(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    logic seen;
    seen      = 1'b0;
    we_a[i]   = we;
    addr_a[i] = a;
    wd_a[i]   = d;
    vld[i]    = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    check($sformatf("accept_req%0d", i), {31'd0, seen}, 32'd1);
  endtask

  // Wait (bounded) until requester i has seen target responses in total.
  task automatic wait_rsp(input int i, input int target);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rsp_cnt[i] >= target) break;
    end
    check($sformatf("rsp_count_req%0d", i), rsp_cnt[i], target);
  endtask

  task automatic run_reqs(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      issue(i, 1'b0, 16'h0100 * 16'(i + 1) + 16'(k), 16'h0000);
    end
    vld[i] = 1'b0;
  endtask

  int exp_order [8];
  int b0, b1, br1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 16'h0000; wd_a[i] = 16'h0000;
    end
    ebi_din = 16'h0000;
    rst     = 1'b1;
    repeat (3) tick();
    // Reset state
    check("rst_strobes", {29'd0, ebi_cs, ebi_rden, ebi_wren}, 32'd7);
    check("rst_addr", ebi_addr, 16'h0000);
    check("rst_dout", ebi_dout, 16'h0000);
    check("rst_rdata", rsp_rdata, 16'h0000);
    check("rst_ready_rsp", {req_ready, rsp_valid}, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single write from requester 0
    issue(0, 1'b1, 16'h1234, 16'hBEEF);
    vld[0] = 1'b0;
    wait_rsp(0, 1);
    check("wr_latency", rsp_cyc[0] - ready_cyc[0], 6);
    check("wr_cs_len", cs_last, 5);
    check("wr_wren_len", wren_last, 3);
    check("wr_wren_offset", wren_off, 2);
    check("wr_no_rden", rden_last, 0);
    check("wr_addr", ebi_addr, 16'h1234);
    check("wr_dout", ebi_dout, 16'hBEEF);

    // Single read from requester 1
    ebi_din = 16'hA55A;
    issue(1, 1'b0, 16'h0042, 16'h0000);
    vld[1] = 1'b0;
    wait_rsp(1, 1);
    check("rd_latency", rsp_cyc[1] - ready_cyc[1], 9);
    check("rd_rden_len", rden_last, 8);
    check("rd_cs_len", cs_last, 8);
    check("rd_rsp_data", rsp_data, 16'hA55A);
    ebi_din = 16'h0000;
    tick();
    check("rd_rdata_hold", rsp_rdata, 16'hA55A);
    check("rd_addr", ebi_addr, 16'h0042);
    check("rd_dout_hold", ebi_dout, 16'hBEEF);

    // Contention: both requesters keep 4 reads each pending
    ebi_din = 16'h3C3C;
    gq.delete();
    gcyc.delete();
    b0 = rsp_cnt[0];
    b1 = rsp_cnt[1];
`ifdef EBI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    fork
      run_reqs(0, 4);
      run_reqs(1, 4);
    join
    wait_rsp(1, b1 + 4);
    check("cont_rsp_req0", rsp_cnt[0], b0 + 4);
    check("cont_grants", gq.size(), 8);
    for (int k = 0; k < gq.size() && k < 8; k++) begin
      check($sformatf("cont_order_%0d", k), gq[k], exp_order[k]);
    end
    for (int k = 1; k < gcyc.size(); k++) begin
      check($sformatf("cont_spacing_%0d", k), gcyc[k] - gcyc[k-1], 11);
    end
    check("cont_rsp_data", rsp_data, 16'h3C3C);

    // Reset in the middle of a read (cnt == 3)
    b0 = rsp_cnt[0];
    issue(0, 1'b0, 16'h0777, 16'h0000);
    vld[0] = 1'b0;
    repeat (3) tick();
    check("pre_rst_rden", ebi_rden, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", {29'd0, ebi_cs, ebi_rden, ebi_wren}, 32'd7);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    check("mid_rst_no_rsp", rsp_cnt[0], b0);

    // After reset, requester 0 wins a simultaneous request
    gq.delete();
    b0 = rsp_cnt[0];
    b1 = rsp_cnt[1];
    fork
      begin issue(0, 1'b1, 16'h0010, 16'h1111); vld[0] = 1'b0; end
      begin issue(1, 1'b0, 16'h0020, 16'h0000); vld[1] = 1'b0; end
    join
    wait_rsp(1, b1 + 1);
    check("post_rst_rsp0", rsp_cnt[0], b0 + 1);
    check("post_rst_grants", gq.size(), 2);
    if (gq.size() >= 2) begin
      check("post_rst_first", gq[0], 0);
      check("post_rst_second", gq[1], 1);
    end

    // Withdrawn request: req1 valid for one cycle during a req0 write
    br1 = ready_cnt[1];
    b1  = rsp_cnt[1];
    b0  = rsp_cnt[0];
    issue(0, 1'b1, 16'h0055, 16'h5555);
    vld[0] = 1'b0;
    tick();
    we_a[1] = 1'b1; addr_a[1] = 16'h0099; wd_a[1] = 16'h9999; vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    wait_rsp(0, b0 + 1);
    repeat (5) tick();
    check("wd_no_ready1", ready_cnt[1], br1);
    check("wd_no_rsp1", rsp_cnt[1], b1);
    check("wd_addr", ebi_addr, 16'h0055);
    check("wd_dout", ebi_dout, 16'h5555);

    // Back-to-back writes from one requester: grant spacing
    gcyc.delete();
    b0 = rsp_cnt[0];
    issue(0, 1'b1, 16'h0A00, 16'h1234);
    issue(0, 1'b1, 16'h0A01, 16'h5678);
    vld[0] = 1'b0;
    wait_rsp(0, b0 + 2);
    check("wr_b2b_grants", gcyc.size(), 2);
    if (gcyc.size() >= 2) check("wr_b2b_spacing", gcyc[1] - gcyc[0], 8);
    check("wr_b2b_dout", ebi_dout, 16'h5678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ebi_arbiter.md
Name: ebi_arbiter

Overview:
- Shares one active-low EBI slave bus between NUM_REQ independent requesters, for example a UART bridge and a second host port.
- Each requester issues single 16-bit read or write commands over a valid/ready request plus a one-cycle response pulse.
- The block arbitrates between requesters, then drives the EBI strobe sequence with programmable cycle counts and returns read data.
- It sits between the command front-ends and the EBI pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WR_SETUP, 2, cycles from cs low to wren low.
- WR_TOTAL, 5, cycles from cs low to end of write; must be greater than WR_SETUP.
- RD_TOTAL, 8, cycles from cs/rden low to sampling of ebi_din (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  16*NUM_REQ  address; requester i uses bits [16i+15:16i].
- req_wdata  in  16*NUM_REQ  write data, same packing as req_addr.
- req_ready  out  NUM_REQ  one-hot pulse: command of requester i accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- rsp_rdata  out  16  read data; valid while rsp_valid is set, otherwise holds its last value.
- ebi_cs  out  1  chip select, active low.
- ebi_rden  out  1  read strobe, active low.
- ebi_wren  out  1  write strobe, active low.
- ebi_addr  out  16  EBI address.
- ebi_dout  out  16  EBI write data.
- ebi_din  in  16  EBI read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - ebi_cs, ebi_rden, ebi_wren = 1.
  - ebi_addr, ebi_dout, rsp_rdata = 0.
  - req_ready, rsp_valid = 0; busy = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: all strobes return high immediately (asynchronous). The in-flight command is dropped and no rsp_valid is issued.
- FSM states: IDLE, WR, RD, GAP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_ready[g], latch addr, wdata and we, update pointer to g, and move to WR or RD.
  - On the next cycle ebi_cs=0 and ebi_addr is driven. For a write, ebi_dout is driven; for a read, ebi_rden=0.
  - The data is passed through unchanged; byte ordering is the requester's responsibility.
- Cycle counter cnt (4 bits): cleared on entering WR or RD, increments by 1 per cycle.
- WR:
  - When cnt==WR_SETUP, drive ebi_wren=0.
  - When cnt==WR_TOTAL, drive cs/wren high, pulse rsp_valid[g], and go to GAP.
- RD:
  - When cnt==RD_TOTAL, capture ebi_din into rsp_rdata, drive cs/rden high, pulse rsp_valid[g], and go to GAP.
- GAP: one turnaround cycle with cs high, then IDLE. No grant is made in GAP.
- Default latencies:
  - Write: acceptance to rsp_valid = 6 cycles.
  - Read: acceptance to rsp_valid = 9 cycles.
  - Back-to-back grant spacing: write 8 cycles, read 11 cycles.
- ebi_addr and ebi_dout hold their values after a transaction until the next grant.
- A requester must hold req_valid and its fields stable until req_ready. The requester may drop req_valid before it is granted without side effects.
- Simultaneous requests are always served in round-robin order. A requester that is continuously valid waits at most NUM_REQ-1 transactions.
- An invalid state encoding recovers to IDLE with the strobes high.

Optional Feature:
- Macro: EBI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index always wins and the pointer is unused. The GAP cycle is still enforced.
- Undefined: round-robin as described above.

Decomposition:
- Package ebi_pkg holds:
  - the state encoding (IDLE, WR, RD, GAP);
  - EBI_AW=16 and EBI_DW=16;
  - the strobe idle level constant EBI_STROBE_IDLE=1'b1.
- Sub-module rr_arbiter (NUM_REQ; inputs req and ptr; outputs one-hot grant and grant index) is purely combinational.
  - The same rr_arbiter is reusable by other shared-resource blocks.

Test Plan:
- Single write: req0 write addr 0x1234, data 0xBEEF.
  - ebi_cs low for 5 cycles; ebi_wren low for cycles 2–4 of cs-low.
  - ebi_addr=0x1234, ebi_dout=0xBEEF; rsp_valid[0] 6 cycles after req_ready[0].
- Single read: req1 read 0x0042 with ebi_din=0xA55A held.
  - ebi_rden low for 8 cycles; rsp_rdata=0xA55A with rsp_valid[1] 9 cycles after acceptance.
- Contention: req0 and req1 both held valid for 4 reads each.
  - Grants alternate 0,1,0,1…; every adjacent pair of transactions has exactly 1 GAP cycle with cs high.
- Reset mid-read: assert rst at cnt=3.
  - ebi_cs, ebi_rden and ebi_wren go to 1 in the same cycle; no rsp_valid pulse.
  - After release, a new request is served normally starting from requester 0.
- Withdrawn request: req1 valid for 1 cycle while a req0 write is in progress, then dropped.
  - No grant and no pulse for req1.
- EBI_ARB_FIXED_PRIO_EN defined, both requesters held valid.
  - Requester 0 wins every grant; requester 1 is granted only after req0 deasserts.
